// File: rtl/register_8_pkg.sv
// Shared definitions for the register_8 storage element: default word
// width, default reset value and the matching word type.
package register_8_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/register_8_parity.sv
// Even-parity generator: reduction XOR over a WIDTH-bit word. Purely
// combinational; the caller registers the result next to the data it covers.
module register_8_parity
  import register_8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] word,
  output logic             par
);

  // XOR of every bit: 1 when the word holds an odd number of ones
  always_comb begin
    par = ^word;
  end

endmodule

// File: rtl/register_8.sv
// Parallel-load data register with hold and a "loaded since reset" flag.
// Compile with REGISTER_8_PARITY_EN defined to add the registered even-parity
// output dout_par; without it the port and its flop are absent.
module register_8
  import register_8_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             loaded
`ifdef REGISTER_8_PARITY_EN
  ,
  output logic             dout_par
`endif
);

  // Data word: captured on a load edge, otherwise held; forced to
  // RESET_VALUE the moment reset drops, without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= RESET_VALUE;
    end else if (ld) begin
      dout <= din;
    end
  end

  // Sticky flag: sets on the first load after reset, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loaded <= 1'b0;
    end else if (ld) begin
      loaded <= 1'b1;
    end
  end

`ifdef REGISTER_8_PARITY_EN
  logic din_par;

  register_8_parity #(
    .WIDTH (WIDTH)
  ) u_parity (
    .word (din),
    .par  (din_par)
  );

  // Parity is computed from din and captured on the same edge as dout,
  // so dout_par always describes the word currently on dout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_par <= ^RESET_VALUE;
    end else if (ld) begin
      dout_par <= din_par;
    end
  end
`endif

endmodule

// File: tb/tb_register_8.sv
// Directed self-checking bench for register_8: default 8-bit instance plus a
// 16-bit instance with a non-zero reset value.
`timescale 1ns/1ps
module tb_register_8;

  logic        clk;
  logic        reset;
  logic        ld;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        loaded;

  logic        reset16;
  logic        ld16;
  logic [15:0] din16;
  logic [15:0] dout16;
  logic        loaded16;

`ifdef REGISTER_8_PARITY_EN
  logic        dout_par;
  logic        dout_par16;
`endif

  int checks;
  int failures;

  register_8 dut (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld),
    .din    (din),
    .dout   (dout),
    .loaded (loaded)
`ifdef REGISTER_8_PARITY_EN
    ,
    .dout_par (dout_par)
`endif
  );

  register_8 #(
    .WIDTH       (16),
    .RESET_VALUE (16'hA5A5)
  ) dut16 (
    .clk    (clk),
    .reset  (reset16),
    .ld     (ld16),
    .din    (din16),
    .dout   (dout16),
    .loaded (loaded16)
`ifdef REGISTER_8_PARITY_EN
    ,
    .dout_par (dout_par16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at the falling edge, sample 1 ns after the following rising edge
  task automatic step(input logic l, input logic [7:0] d);
    @(negedge clk);
    ld  = l;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_dout got=%h want=%h", dout, 8'h00);
    end
    checks++;
    if (loaded !== 1'b0) begin
      failures++;
      $display("FAIL reset_loaded got=%b want=%b", loaded, 1'b0);
    end
`ifdef REGISTER_8_PARITY_EN
    checks++;
    if (dout_par !== 1'b0) begin
      failures++;
      $display("FAIL reset_par got=%b want=%b", dout_par, 1'b0);
    end
`endif
  endtask

  task automatic test_sequential_loads;
    logic [7:0] vec [3];
    vec[0] = 8'h00; vec[1] = 8'h01; vec[2] = 8'hFF;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vec[i]);
      checks++;
      if (dout !== vec[i]) begin
        failures++;
        $display("FAIL seq_load%0d got=%h want=%h", i, dout, vec[i]);
      end
      checks++;
      if (loaded !== 1'b1) begin
        failures++;
        $display("FAIL seq_loaded%0d got=%b want=%b", i, loaded, 1'b1);
      end
    end
  endtask

  task automatic test_hold;
    step(1'b0, 8'h55);
    checks++;
    if (dout !== 8'hFF) begin
      failures++;
      $display("FAIL hold_55 got=%h want=%h", dout, 8'hFF);
    end
    step(1'b0, 8'hxx);
    checks++;
    if (dout !== 8'hFF) begin
      failures++;
      $display("FAIL hold_x got=%h want=%h", dout, 8'hFF);
    end
`ifdef REGISTER_8_PARITY_EN
    checks++;
    if (dout_par !== 1'b0) begin
      failures++;
      $display("FAIL hold_par got=%b want=%b", dout_par, 1'b0);
    end
`endif
    step(1'b1, 8'hAA);
    checks++;
    if (dout !== 8'hAA) begin
      failures++;
      $display("FAIL hold_then_load got=%h want=%h", dout, 8'hAA);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vec [3];
    vec[0] = 8'hBA; vec[1] = 8'h0B; vec[2] = 8'hAB;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vec[i]);
      checks++;
      if (dout !== vec[i]) begin
        failures++;
        $display("FAIL b2b%0d got=%h want=%h", i, dout, vec[i]);
      end
`ifdef REGISTER_8_PARITY_EN
      checks++;
      if (dout_par !== 1'b1) begin
        failures++;
        $display("FAIL b2b_par%0d got=%b want=%b", i, dout_par, 1'b1);
      end
`endif
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    ld  = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL async_dout got=%h want=%h", dout, 8'h00);
    end
    checks++;
    if (loaded !== 1'b0) begin
      failures++;
      $display("FAIL async_loaded got=%b want=%b", loaded, 1'b0);
    end
    step(1'b1, 8'h77);
    checks++;
    if (dout !== 8'h00) begin
      failures++;
      $display("FAIL load_in_reset got=%h want=%h", dout, 8'h00);
    end
    checks++;
    if (loaded !== 1'b0) begin
      failures++;
      $display("FAIL loaded_in_reset got=%b want=%b", loaded, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    ld    = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (loaded !== 1'b0 || dout !== 8'h00) begin
      failures++;
      $display("FAIL idle_after_release got=%h/%b want=%h/%b", dout, loaded, 8'h00, 1'b0);
    end
    step(1'b1, 8'h3C);
    checks++;
    if (dout !== 8'h3C || loaded !== 1'b1) begin
      failures++;
      $display("FAIL load_after_release got=%h/%b want=%h/%b", dout, loaded, 8'h3C, 1'b1);
    end
    // Reloading the same value is still a load
    step(1'b1, 8'h3C);
    checks++;
    if (dout !== 8'h3C || loaded !== 1'b1) begin
      failures++;
      $display("FAIL same_value_load got=%h/%b want=%h/%b", dout, loaded, 8'h3C, 1'b1);
    end
  endtask

  task automatic test_param_width16;
    checks++;
    if (dout16 !== 16'hA5A5 || loaded16 !== 1'b0) begin
      failures++;
      $display("FAIL w16_reset got=%h/%b want=%h/%b", dout16, loaded16, 16'hA5A5, 1'b0);
    end
`ifdef REGISTER_8_PARITY_EN
    checks++;
    if (dout_par16 !== 1'b0) begin
      failures++;
      $display("FAIL w16_reset_par got=%b want=%b", dout_par16, 1'b0);
    end
`endif
    @(negedge clk);
    reset16 = 1'b1;
    ld16    = 1'b1;
    din16   = 16'h1234;
    @(posedge clk);
    #1;
    checks++;
    if (dout16 !== 16'h1234 || loaded16 !== 1'b1) begin
      failures++;
      $display("FAIL w16_load got=%h/%b want=%h/%b", dout16, loaded16, 16'h1234, 1'b1);
    end
`ifdef REGISTER_8_PARITY_EN
    checks++;
    if (dout_par16 !== 1'b1) begin
      failures++;
      $display("FAIL w16_par got=%b want=%b", dout_par16, 1'b1);
    end
`endif
    @(negedge clk);
    ld16 = 1'b0;
    #1;
    reset16 = 1'b0;
    #1;
    checks++;
    if (dout16 !== 16'hA5A5) begin
      failures++;
      $display("FAIL w16_async got=%h want=%h", dout16, 16'hA5A5);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    ld       = 1'b0;
    din      = 8'h00;
    reset16  = 1'b0;
    ld16     = 1'b0;
    din16    = 16'h0000;

    test_reset();
    test_sequential_loads();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_param_width16();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
